// File: rtl/load_store_pkg.sv
// -----------------------------------------------------------------------------
// load_store_pkg
// Shared types and constants for the load/store peak-pulse monitor.
//   ls_state_t  : monitor FSM states
//   ERR_*       : err_code encodings
//   ls_period() : cycles per generator period for peak level n, high run hw
// -----------------------------------------------------------------------------
package load_store_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        FAIL = 2'd3
    } ls_state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_HIGH      = 2'b01;
    localparam logic [1:0] ERR_LOW_SHORT = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

    // Two ramps of n steps each plus the high run at the peak.
    function automatic int ls_period(input int n, input int hw);
        return 2 * n + hw;
    endfunction

endpackage

// File: rtl/load_store_monitor_run_counter.sv
// -----------------------------------------------------------------------------
// ls_run_counter
// Run-length counter: clear to 0, load 1, or increment; flags when the count
// equals LIMIT so the FSM never needs the raw value.
//   clk      : clock
//   rst      : synchronous active-high reset (count -> 0)
//   clr      : count -> 0
//   set1     : count -> 1 (start of a new run)
//   inc      : count -> count + 1
//   at_limit : count == LIMIT
// Priority: rst/clr > set1 > inc.
// -----------------------------------------------------------------------------
module ls_run_counter #(
    parameter int W     = 16,
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic set1,
    input  logic inc,
    output logic at_limit
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (set1) begin
            count <= W'(1);
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == W'(LIMIT));

endmodule

// File: rtl/load_store_monitor.sv
// -----------------------------------------------------------------------------
// load_store_monitor
// Checks the peak-pulse line of a triangular load/store level generator:
// expects HW cycles high then LW = 2N cycles low, forever. Reports lock,
// measured period, peak count and the first protocol error.
//   clk        : clock
//   rst        : synchronous active-high reset
//   sig        : peak-pulse line, sampled every posedge
//   locked     : LOCK_PEAKS consecutive good periods seen
//   err        : error flag (sticky, or 1-cycle pulse with resync)
//   err_code   : 00 none, 01 high run wrong, 10 low run short, 11 low timeout
//   period_q   : cycles between the last two good rising edges
//   peak_count : rising edges seen, wraps
//   err_cnt    : saturating error count (0 unless resync is enabled)
// Optional: define LOAD_STORE_MONITOR_RESYNC_EN to resynchronise after an
// error instead of sticking in FAIL.
// -----------------------------------------------------------------------------
module load_store_monitor
    import load_store_pkg::*;
#(
    parameter int N          = 20000,
    parameter int HW         = 2,
    parameter int CBITS      = 16,
    parameter int PCBITS     = 16,
    parameter int LOCK_PEAKS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig,
    output logic              locked,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CBITS-1:0]  period_q,
    output logic [PCBITS-1:0] peak_count,
    output logic [7:0]        err_cnt
);

    localparam int LW    = ls_period(N, HW) - HW;
    localparam int GBITS = $clog2(LOCK_PEAKS + 1);

    ls_state_t         state, state_n;
    logic              h_at, h_set, h_inc;
    logic              l_at, l_clr, l_set, l_inc;
    logic [CBITS-1:0]  pcnt, pcnt_n;
    logic [GBITS-1:0]  good, good_n;
    logic              locked_n, err_n, err_hit;
    logic [1:0]        err_code_n, hit_code;
    logic [CBITS-1:0]  period_n;
    logic [PCBITS-1:0] peak_n;

    ls_run_counter #(.W(CBITS), .LIMIT(HW)) u_hrun (
        .clk(clk), .rst(rst), .clr(1'b0), .set1(h_set), .inc(h_inc), .at_limit(h_at)
    );

    ls_run_counter #(.W(CBITS), .LIMIT(LW)) u_lrun (
        .clk(clk), .rst(rst), .clr(l_clr), .set1(l_set), .inc(l_inc), .at_limit(l_at)
    );

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n    = state;
        h_set      = 1'b0;
        h_inc      = 1'b0;
        l_clr      = 1'b0;
        l_set      = 1'b0;
        l_inc      = 1'b0;
        locked_n   = locked;
        err_code_n = err_code;
        period_n   = period_q;
        peak_n     = peak_count;
        good_n     = good;
        pcnt_n     = (state == FAIL) ? pcnt : pcnt + 1'b1;
        err_hit    = 1'b0;
        hit_code   = ERR_NONE;
`ifdef LOAD_STORE_MONITOR_RESYNC_EN
        err_n      = 1'b0;      // err is a single-cycle pulse
`else
        err_n      = err;       // err is sticky
`endif

        case (state)
            SYNC: begin
                if (sig) begin
                    // First edge: no low-length check, period not measured.
                    state_n = HIGH;
                    h_set   = 1'b1;
                    peak_n  = peak_count + 1'b1;
                    pcnt_n  = CBITS'(1);
                end else if (l_at) begin
                    err_hit  = 1'b1;
                    hit_code = ERR_TIMEOUT;
                end else begin
                    l_inc = 1'b1;
                end
            end
            HIGH: begin
                if (sig == h_at) begin
                    // Either a too-long run or a run ending early.
                    err_hit  = 1'b1;
                    hit_code = ERR_HIGH;
                end else if (sig) begin
                    h_inc = 1'b1;
                end else begin
                    state_n = LOW;
                    l_set   = 1'b1;
                end
            end
            LOW: begin
                if (!sig) begin
                    if (l_at) begin
                        err_hit  = 1'b1;
                        hit_code = ERR_TIMEOUT;
                    end else begin
                        l_inc = 1'b1;
                    end
                end else if (!l_at) begin
                    err_hit  = 1'b1;
                    hit_code = ERR_LOW_SHORT;
                end else begin
                    state_n  = HIGH;
                    h_set    = 1'b1;
                    peak_n   = peak_count + 1'b1;
                    period_n = pcnt;
                    pcnt_n   = CBITS'(1);
                    if (good != GBITS'(LOCK_PEAKS)) begin
                        good_n = good + 1'b1;
                    end
                    locked_n = (good_n == GBITS'(LOCK_PEAKS));
                end
            end
            default: ;  // FAIL holds everything until rst
        endcase

        if (err_hit) begin
            err_n      = 1'b1;
            err_code_n = hit_code;
            locked_n   = 1'b0;
            good_n     = '0;
`ifdef LOAD_STORE_MONITOR_RESYNC_EN
            state_n    = SYNC;
            l_clr      = 1'b1;
`else
            state_n    = FAIL;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked     <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            period_q   <= '0;
            peak_count <= '0;
            pcnt       <= '0;
            good       <= '0;
        end else begin
            locked     <= locked_n;
            err        <= err_n;
            err_code   <= err_code_n;
            period_q   <= period_n;
            peak_count <= peak_n;
            pcnt       <= pcnt_n;
            good       <= good_n;
        end
    end

`ifdef LOAD_STORE_MONITOR_RESYNC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_hit && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_load_store_monitor.sv
// -----------------------------------------------------------------------------
// tb_load_store_monitor
// Directed bench for load_store_monitor with N=4 (LW=8, period 10),
// LOCK_PEAKS=2. Expected values are hand-computed from the stream shapes.
// -----------------------------------------------------------------------------
module tb_load_store_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig = 1'b0;
    logic        locked;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] period_q;
    logic [15:0] peak_count;
    logic [7:0]  err_cnt;

    int passed = 0;
    int total  = 0;
    bit err_seen;

    load_store_monitor #(
        .N(4), .HW(2), .CBITS(16), .PCBITS(16), .LOCK_PEAKS(2)
    ) dut (
        .clk(clk), .rst(rst), .sig(sig), .locked(locked), .err(err),
        .err_code(err_code), .period_q(period_q), .peak_count(peak_count),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Drive one sample, let it be taken at posedge, look 1 time unit later.
    task automatic step(input logic v);
        sig = v;
        @(posedge clk);
        #1;
        if (err) err_seen = 1'b1;
    endtask

    task automatic lows(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic period();
        step(1'b1);
        step(1'b1);
        lows(8);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sig = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        err_seen = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({locked, err, err_code, period_q, peak_count, err_cnt} !== 44'h0) begin
            $display("FAIL reset_state: got %h required 0",
                     {locked, err, err_code, period_q, peak_count, err_cnt});
        end else passed++;
    endtask

    task automatic test_golden();
        do_reset();
        lows(5);
        for (int p = 1; p <= 3; p++) begin
            step(1'b1);
            total++;
            if (peak_count !== 16'(p)) begin
                $display("FAIL golden_peak%0d: got %0d required %0d", p, peak_count, p);
            end else passed++;
            total++;
            if (locked !== (p == 3)) begin
                $display("FAIL golden_lock%0d: got %0b required %0b", p, locked, (p == 3));
            end else passed++;
            total++;
            if (period_q !== ((p == 1) ? 16'd0 : 16'd10)) begin
                $display("FAIL golden_period%0d: got %0d required %0d", p, period_q,
                         (p == 1) ? 0 : 10);
            end else passed++;
            if (p < 3) begin
                step(1'b1);
                lows(8);
            end
        end
        total++;
        if (err_seen !== 1'b0 || err_code !== 2'b00) begin
            $display("FAIL golden_no_err: got err_seen=%0b code=%0b required 0/00",
                     err_seen, err_code);
        end else passed++;
    endtask

    task automatic test_high_err();
        do_reset();
        lows(5);
        period();
        period();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        total++;
        if ({err, err_code, locked} !== 4'b1010 || peak_count !== 16'd3) begin
            $display("FAIL high_err: got err=%0b code=%0b locked=%0b peaks=%0d required 1/01/0/3",
                     err, err_code, locked, peak_count);
        end else passed++;
`ifndef LOAD_STORE_MONITOR_RESYNC_EN
        step(1'b0);
        period();
        step(1'b1);
        total++;
        if ({err, err_code, locked} !== 4'b1010 || peak_count !== 16'd3) begin
            $display("FAIL high_err_sticky: got err=%0b code=%0b locked=%0b peaks=%0d required 1/01/0/3",
                     err, err_code, locked, peak_count);
        end else passed++;
`endif
    endtask

    task automatic test_low_short();
        do_reset();
        step(1'b1);
        step(1'b1);
        lows(7);
        total++;
        if (err !== 1'b0) begin
            $display("FAIL low7_no_err: got err=%0b required 0", err);
        end else passed++;
        step(1'b1);
        total++;
        if ({err, err_code} !== 3'b110 || peak_count !== 16'd1) begin
            $display("FAIL low_short: got err=%0b code=%0b peaks=%0d required 1/10/1",
                     err, err_code, peak_count);
        end else passed++;
    endtask

    task automatic test_timeout();
        // Boundary in SYNC: 8 lows allowed, the 9th times out.
        do_reset();
        lows(8);
        total++;
        if (err !== 1'b0) begin
            $display("FAIL sync_8_lows: got err=%0b required 0", err);
        end else passed++;
        step(1'b0);
        total++;
        if ({err, err_code} !== 3'b111) begin
            $display("FAIL sync_timeout: got err=%0b code=%0b required 1/11", err, err_code);
        end else passed++;

        do_reset();
        lows(5);
        period();
        period();
        step(1'b1);
        step(1'b1);
        lows(8);
        total++;
        if (err !== 1'b0 || locked !== 1'b1) begin
            $display("FAIL low_8_lows: got err=%0b locked=%0b required 0/1", err, locked);
        end else passed++;
        step(1'b0);
        total++;
        if ({err, err_code, locked} !== 4'b1110) begin
            $display("FAIL low_timeout: got err=%0b code=%0b locked=%0b required 1/11/0",
                     err, err_code, locked);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        lows(5);
        period();
        period();
        step(1'b1);
        total++;
        if (locked !== 1'b1) begin
            $display("FAIL mid_pre_lock: got %0b required 1", locked);
        end else passed++;
        rst = 1'b1;
        sig = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({locked, err, err_code, period_q, peak_count, err_cnt} !== 44'h0) begin
            $display("FAIL mid_reset_state: got %h required 0",
                     {locked, err, err_code, period_q, peak_count, err_cnt});
        end else passed++;
        lows(5);
        for (int p = 1; p <= 3; p++) begin
            step(1'b1);
            total++;
            if (locked !== (p == 3) || peak_count !== 16'(p)) begin
                $display("FAIL mid_relock%0d: got locked=%0b peaks=%0d required %0b/%0d",
                         p, locked, peak_count, (p == 3), p);
            end else passed++;
            if (p < 3) begin
                step(1'b1);
                lows(8);
            end
        end
    endtask

`ifdef LOAD_STORE_MONITOR_RESYNC_EN
    task automatic test_resync();
        do_reset();
        lows(5);
        period();
        period();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        total++;
        if ({err, err_code, locked} !== 4'b1010 || err_cnt !== 8'd1) begin
            $display("FAIL resync_err: got err=%0b code=%0b locked=%0b cnt=%0d required 1/01/0/1",
                     err, err_code, locked, err_cnt);
        end else passed++;
        step(1'b0);
        total++;
        if (err !== 1'b0 || err_code !== 2'b01 || err_cnt !== 8'd1) begin
            $display("FAIL resync_pulse: got err=%0b code=%0b cnt=%0d required 0/01/1",
                     err, err_code, err_cnt);
        end else passed++;
        lows(4);
        for (int p = 4; p <= 6; p++) begin
            step(1'b1);
            total++;
            if (locked !== (p == 6) || peak_count !== 16'(p) || period_q !== 16'd10) begin
                $display("FAIL resync_relock%0d: got locked=%0b peaks=%0d period=%0d required %0b/%0d/10",
                         p, locked, peak_count, period_q, (p == 6), p);
            end else passed++;
            if (p < 6) begin
                step(1'b1);
                lows(8);
            end
        end
        total++;
        if (err_cnt !== 8'd1 || err !== 1'b0) begin
            $display("FAIL resync_cnt: got cnt=%0d err=%0b required 1/0", err_cnt, err);
        end else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_golden();
        test_high_err();
        test_low_short();
        test_timeout();
        test_reset_mid();
`ifdef LOAD_STORE_MONITOR_RESYNC_EN
        test_resync();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
